// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - MIPS-subset instruction decode and ID/EX pipeline register
// Decodes logical, shift, immediate, lui and lw instructions and detects load-use hazards.
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic [31:0]       id_pc_i,
    input  logic [31:0]       id_inst_i,
    output logic [ADDR_W-1:0] reg1_addr_o,
    output logic [ADDR_W-1:0] reg2_addr_o,
    output logic              reg1_read_o,
    output logic              reg2_read_o,
    input  logic [DATA_W-1:0] reg1_data_i,
    input  logic [DATA_W-1:0] reg2_data_i,
    output logic              stallreq_o,
    output logic [3:0]        ex_aluop_o,
    output logic [DATA_W-1:0] ex_reg1_o,
    output logic [DATA_W-1:0] ex_reg2_o,
    output logic [ADDR_W-1:0] ex_waddr_o,
    output logic              ex_wreg_o,
    output logic [31:0]       ex_pc_o
);

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_OR  = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_XOR = 4'd3;
    localparam logic [3:0] ALU_NOR = 4'd4;
    localparam logic [3:0] ALU_SLL = 4'd5;
    localparam logic [3:0] ALU_SRL = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_LW  = 4'd8;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm;

    assign op    = id_inst_i[31:26];
    assign rs    = id_inst_i[25:21];
    assign rt    = id_inst_i[20:16];
    assign rd    = id_inst_i[15:11];
    assign shamt = id_inst_i[10:6];
    assign funct = id_inst_i[5:0];
    assign imm   = id_inst_i[15:0];

    logic [3:0]        dec_aluop;
    logic              dec_read1;
    logic              dec_read2;
    logic              dec_shift;
    logic [DATA_W-1:0] dec_imm;
    logic [ADDR_W-1:0] dec_waddr;
    logic              dec_valid;

    always_comb begin
        dec_aluop = ALU_NOP;
        dec_read1 = 1'b0;
        dec_read2 = 1'b0;
        dec_shift = 1'b0;
        dec_imm   = '0;
        dec_waddr = '0;
        dec_valid = 1'b1;
        case (op)
            6'h00: begin
                case (funct)
                    6'h24, 6'h25, 6'h26, 6'h27: begin
                        case (funct[1:0])
                            2'd0:    dec_aluop = ALU_AND;
                            2'd1:    dec_aluop = ALU_OR;
                            2'd2:    dec_aluop = ALU_XOR;
                            default: dec_aluop = ALU_NOR;
                        endcase
                        dec_read1 = 1'b1;
                        dec_read2 = 1'b1;
                        dec_waddr = ADDR_W'(rd);
                    end
                    6'h00, 6'h02, 6'h03: begin
                        case (funct[1:0])
                            2'd0:    dec_aluop = ALU_SLL;
                            2'd2:    dec_aluop = ALU_SRL;
                            default: dec_aluop = ALU_SRA;
                        endcase
                        // rt comes in on port 2 but feeds operand 1; shamt is operand 2
                        dec_read2 = 1'b1;
                        dec_shift = 1'b1;
                        dec_imm   = DATA_W'(shamt);
                        dec_waddr = ADDR_W'(rd);
                    end
                    default: dec_valid = 1'b0;
                endcase
            end
            6'h0C, 6'h0D, 6'h0E: begin
                case (op[1:0])
                    2'd0:    dec_aluop = ALU_AND;
                    2'd1:    dec_aluop = ALU_OR;
                    default: dec_aluop = ALU_XOR;
                endcase
                dec_read1 = 1'b1;
                dec_imm   = DATA_W'(imm);
                dec_waddr = ADDR_W'(rt);
            end
            6'h0F: begin
                dec_aluop = ALU_OR;
                dec_imm   = DATA_W'({imm, 16'h0000});
                dec_waddr = ADDR_W'(rt);
            end
            6'h23: begin
                dec_aluop = ALU_LW;
                dec_read1 = 1'b1;
                dec_imm   = DATA_W'($signed(imm));
                dec_waddr = ADDR_W'(rt);
            end
            default: dec_valid = 1'b0;
        endcase
    end

    // Register-file read interface is silenced during reset
    assign reg1_read_o = dec_read1 & ~rst;
    assign reg2_read_o = dec_read2 & ~rst;
    assign reg1_addr_o = reg1_read_o ? ADDR_W'(rs) : '0;
    assign reg2_addr_o = reg2_read_o ? ADDR_W'(rt) : '0;

    logic [DATA_W-1:0] dec_reg1;
    logic [DATA_W-1:0] dec_reg2;
    logic              dec_wreg;

    always_comb begin
        dec_reg1 = '0;
        dec_reg2 = dec_imm;
        if (dec_shift) begin
            dec_reg1 = reg2_data_i;
        end else begin
            if (dec_read1) dec_reg1 = reg1_data_i;
            if (dec_read2) dec_reg2 = reg2_data_i;
        end
    end

    assign dec_wreg = dec_valid & (dec_waddr != '0);

    assign stallreq_o = ~rst && (ex_aluop_o == ALU_LW) && ex_wreg_o &&
                        ((reg1_read_o && (reg1_addr_o == ex_waddr_o)) ||
                         (reg2_read_o && (reg2_addr_o == ex_waddr_o)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_aluop_o <= ALU_NOP;
            ex_reg1_o  <= '0;
            ex_reg2_o  <= '0;
            ex_waddr_o <= '0;
            ex_wreg_o  <= 1'b0;
            ex_pc_o    <= '0;
        end else if (flush_i || (!stall_i && stallreq_o)) begin
            ex_aluop_o <= ALU_NOP;
            ex_reg1_o  <= '0;
            ex_reg2_o  <= '0;
            ex_waddr_o <= '0;
            ex_wreg_o  <= 1'b0;
            ex_pc_o    <= '0;
        end else if (!stall_i) begin
            ex_aluop_o <= dec_aluop;
            ex_reg1_o  <= dec_reg1;
            ex_reg2_o  <= dec_reg2;
            ex_waddr_o <= dec_waddr;
            ex_wreg_o  <= dec_wreg;
            ex_pc_o    <= id_pc_i;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_i;
    logic        flush_i;
    logic [31:0] id_pc_i;
    logic [31:0] id_inst_i;
    logic [4:0]  reg1_addr_o;
    logic [4:0]  reg2_addr_o;
    logic        reg1_read_o;
    logic        reg2_read_o;
    logic [31:0] reg1_data_i;
    logic [31:0] reg2_data_i;
    logic        stallreq_o;
    logic [3:0]  ex_aluop_o;
    logic [31:0] ex_reg1_o;
    logic [31:0] ex_reg2_o;
    logic [4:0]  ex_waddr_o;
    logic        ex_wreg_o;
    logic [31:0] ex_pc_o;

    int checks   = 0;
    int failures = 0;

    id_ex_stage #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall_i     (stall_i),
        .flush_i     (flush_i),
        .id_pc_i     (id_pc_i),
        .id_inst_i   (id_inst_i),
        .reg1_addr_o (reg1_addr_o),
        .reg2_addr_o (reg2_addr_o),
        .reg1_read_o (reg1_read_o),
        .reg2_read_o (reg2_read_o),
        .reg1_data_i (reg1_data_i),
        .reg2_data_i (reg2_data_i),
        .stallreq_o  (stallreq_o),
        .ex_aluop_o  (ex_aluop_o),
        .ex_reg1_o   (ex_reg1_o),
        .ex_reg2_o   (ex_reg2_o),
        .ex_waddr_o  (ex_waddr_o),
        .ex_wreg_o   (ex_wreg_o),
        .ex_pc_o     (ex_pc_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex_all(input string tag, input logic [3:0] aluop, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [4:0] wa, input logic wr,
                          input logic [31:0] pc);
        chk({tag, ".aluop"}, 64'(ex_aluop_o), 64'(aluop));
        chk({tag, ".reg1"},  64'(ex_reg1_o),  64'(r1));
        chk({tag, ".reg2"},  64'(ex_reg2_o),  64'(r2));
        chk({tag, ".waddr"}, 64'(ex_waddr_o), 64'(wa));
        chk({tag, ".wreg"},  64'(ex_wreg_o),  64'(wr));
        chk({tag, ".pc"},    64'(ex_pc_o),    64'(pc));
    endtask

    initial begin
        rst         = 1'b1;
        stall_i     = 1'b0;
        flush_i     = 1'b0;
        id_pc_i     = 32'h0000_0000;
        id_inst_i   = 32'h3401_1234;
        reg1_data_i = 32'h0;
        reg2_data_i = 32'h0;

        // reset state: registers bubbled, read interface quiet despite valid ori
        #2;
        ex_all("reset", 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        chk("reset.reg1_read", 64'(reg1_read_o), 64'd0);
        chk("reset.reg1_addr", 64'(reg1_addr_o), 64'd0);
        chk("reset.stallreq",  64'(stallreq_o),  64'd0);

        // ori $1,$0,0x1234
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("ori.reg1_read", 64'(reg1_read_o), 64'd1);
        chk("ori.reg2_read", 64'(reg2_read_o), 64'd0);
        tick();
        ex_all("ori", 4'd1, 32'h0, 32'h0000_1234, 5'd1, 1'b1, 32'h0);

        // lw $2,-4($3)
        @(negedge clk);
        id_inst_i   = 32'h8C62_FFFC;
        id_pc_i     = 32'h0000_0004;
        reg1_data_i = 32'h0000_0100;
        #1;
        chk("lw.reg1_addr", 64'(reg1_addr_o), 64'd3);
        tick();
        ex_all("lw", 4'd8, 32'h0000_0100, 32'hFFFF_FFFC, 5'd2, 1'b1, 32'h4);

        // or $4,$2,$5 after lw: one bubble then capture
        @(negedge clk);
        id_inst_i   = 32'h0045_2025;
        id_pc_i     = 32'h0000_0008;
        reg1_data_i = 32'h0000_00F0;
        reg2_data_i = 32'h0000_000F;
        #1;
        chk("luse.stallreq", 64'(stallreq_o), 64'd1);
        chk("luse.reg1_addr", 64'(reg1_addr_o), 64'd2);
        tick();
        ex_all("luse.bubble", 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        chk("luse.stallreq_clear", 64'(stallreq_o), 64'd0);
        tick();
        ex_all("or", 4'd1, 32'h0000_00F0, 32'h0000_000F, 5'd4, 1'b1, 32'h8);

        // lui $7,0xABCD
        @(negedge clk);
        id_inst_i = 32'h3C07_ABCD;
        id_pc_i   = 32'h0000_000C;
        #1;
        chk("lui.reg1_read", 64'(reg1_read_o), 64'd0);
        chk("lui.reg2_read", 64'(reg2_read_o), 64'd0);
        tick();
        ex_all("lui", 4'd1, 32'h0, 32'hABCD_0000, 5'd7, 1'b1, 32'hC);

        // sra $6,$8,3
        @(negedge clk);
        id_inst_i   = 32'h0008_30C3;
        id_pc_i     = 32'h0000_0010;
        reg1_data_i = 32'h1111_1111;
        reg2_data_i = 32'h8000_0000;
        #1;
        chk("sra.reg1_read", 64'(reg1_read_o), 64'd0);
        chk("sra.reg2_read", 64'(reg2_read_o), 64'd1);
        chk("sra.reg2_addr", 64'(reg2_addr_o), 64'd8);
        tick();
        ex_all("sra", 4'd7, 32'h8000_0000, 32'h3, 5'd6, 1'b1, 32'h10);

        // stall 3 cycles while ID presents xori $9,$1,0x00FF
        @(negedge clk);
        stall_i     = 1'b1;
        id_inst_i   = 32'h3829_00FF;
        id_pc_i     = 32'h0000_0014;
        reg1_data_i = 32'h0000_0F0F;
        for (int i = 0; i < 3; i++) begin
            tick();
            ex_all($sformatf("stall%0d", i), 4'd7, 32'h8000_0000, 32'h3, 5'd6, 1'b1, 32'h10);
        end
        @(negedge clk);
        flush_i = 1'b1;
        tick();
        ex_all("stall_flush", 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        @(negedge clk);
        flush_i = 1'b0;
        stall_i = 1'b0;
        tick();
        ex_all("xori", 4'd3, 32'h0000_0F0F, 32'h0000_00FF, 5'd9, 1'b1, 32'h14);

        // rst pulse between edges clears valid EX state immediately
        #2;
        rst = 1'b1;
        #1;
        ex_all("async_rst", 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        chk("async_rst.reg1_read", 64'(reg1_read_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // undefined opcode decodes as NOP
        id_inst_i = 32'hFC00_0000;
        id_pc_i   = 32'h0000_0018;
        #1;
        chk("undef.reg1_read", 64'(reg1_read_o), 64'd0);
        chk("undef.reg2_read", 64'(reg2_read_o), 64'd0);
        tick();
        ex_all("undef", 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h18);

        // ori $0,$1,5: write to $0 never enables wreg
        @(negedge clk);
        id_inst_i   = 32'h3420_0005;
        id_pc_i     = 32'h0000_001C;
        reg1_data_i = 32'h0000_0030;
        tick();
        ex_all("ori_r0", 4'd1, 32'h0000_0030, 32'h0000_0005, 5'd0, 1'b0, 32'h1C);

        // lw $2,0($3) then and $10,$1,$2 with stall_i overlapping the hazard
        @(negedge clk);
        id_inst_i   = 32'h8C62_0000;
        id_pc_i     = 32'h0000_0020;
        reg1_data_i = 32'h0000_0200;
        tick();
        chk("lw2.aluop", 64'(ex_aluop_o), 64'd8);
        @(negedge clk);
        id_inst_i   = 32'h0022_5024;
        id_pc_i     = 32'h0000_0024;
        reg1_data_i = 32'h0000_00CC;
        reg2_data_i = 32'h0000_00AA;
        stall_i     = 1'b1;
        tick();
        chk("hold_hazard.aluop",    64'(ex_aluop_o), 64'd8);
        chk("hold_hazard.stallreq", 64'(stallreq_o), 64'd1);
        chk("hold_hazard.reg2_addr", 64'(reg2_addr_o), 64'd2);
        @(negedge clk);
        stall_i = 1'b0;
        tick();
        ex_all("hazard_bubble", 4'd0, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
        tick();
        ex_all("and", 4'd2, 32'h0000_00CC, 32'h0000_00AA, 5'd10, 1'b1, 32'h24);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register/data word width.
REQ-002 SHALL provide parameter ADDR_W, default 5, register address width.
REQ-003 SHALL provide port clk  in  1  sole clock.
REQ-004 SHALL provide port rst  in  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL provide port stall_i  in  1  hold ID/EX register (EX stalled).
REQ-006 SHALL provide port flush_i  in  1  load bubble into ID/EX register.
REQ-007 SHALL provide port id_pc_i  in  32  PC of instruction in ID.
REQ-008 SHALL provide port id_inst_i  in  32  instruction word in ID.
REQ-009 SHALL provide ports reg1_addr_o/reg2_addr_o  out  ADDR_W  regfile read addresses.
REQ-010 SHALL provide ports reg1_read_o/reg2_read_o  out  1  regfile read enables.
REQ-011 SHALL provide ports reg1_data_i/reg2_data_i  in  DATA_W  regfile read data, already forwarded.
REQ-012 SHALL provide port stallreq_o  out  1  load-use stall request to IF/ID (combinational).
REQ-013 SHALL provide registered outputs ex_aluop_o (4), ex_reg1_o (DATA_W), ex_reg2_o (DATA_W), ex_waddr_o (ADDR_W), ex_wreg_o (1), ex_pc_o (32).

Function
REQ-014 aluop codes SHALL be: NOP=0, OR=1, AND=2, XOR=3, NOR=4, SLL=5, SRL=6, SRA=7, LW=8.
REQ-015 op=0x00 funct and/or/xor/nor (0x24-0x27): read rs->reg1, rt->reg2, write rd.
REQ-016 op=0x00 funct sll/srl/sra (0x00/0x02/0x03): read rt only; ex_reg1=rt value; ex_reg2=zero-extended shamt; write rd.
REQ-017 andi/ori/xori (0x0C/0x0D/0x0E): read rs->reg1; reg2=zero-extended imm16; write rt.
REQ-018 lui (0x0F): aluop OR; no reads; reg1=0; reg2={imm16,16'h0}; write rt.
REQ-019 lw (0x23): aluop LW; read rs->reg1; reg2=sign-extended imm16; write rt.
REQ-020 Any other encoding SHALL decode as NOP: both read enables 0, wreg 0, operands 0.
REQ-021 reg*_addr_o SHALL equal rs/rt fields whenever the matching read enable is 1; operand for a disabled port SHALL be the immediate/zero per REQ-015..019, never reg*_data_i.
REQ-022 Decoded write address 0 SHALL force wreg to 0.
REQ-023 stallreq_o SHALL be 1 iff ex_aluop_o==LW, ex_wreg_o==1, and (reg1_read_o && reg1_addr_o==ex_waddr_o) or (reg2_read_o && reg2_addr_o==ex_waddr_o).
REQ-024 On each clk rising edge, priority: flush_i -> bubble; else stall_i -> hold all registers; else stallreq_o -> bubble; else capture decoded instruction.
REQ-025 Bubble SHALL be aluop NOP, reg1=reg2=0, waddr=0, wreg=0, pc=0.
REQ-026 Load-use stall SHALL last exactly one cycle absent stall_i/flush_i; the bubble clears the REQ-023 condition.
REQ-027 Decode-to-EX latency SHALL be one clk cycle; no combinational path from id_inst_i to any ex_* output.
REQ-028 stall_i and stallreq_o both high SHALL hold (no bubble); stallreq_o stays asserted while hazard persists.

Reset
REQ-029 rst=1 SHALL asynchronously drive all ex_* registers to bubble values (REQ-025), independent of clk.
REQ-030 While rst=1, reg1_read_o, reg2_read_o, reg*_addr_o and stallreq_o SHALL be 0.
REQ-031 Deassertion SHALL take effect at the first clk edge after rst falls; rst asserted mid-stall SHALL cancel the stall.

Verification
REQ-032 ori $1,$0,0x1234 (0x34011234), reg1_data_i=0 -> next edge aluop=1, reg1=0, reg2=0x00001234, waddr=1, wreg=1.
REQ-033 lw $2,-4($3) (0x8C62FFFC) then or $4,$2,$5 -> stallreq_o=1 one cycle, bubble in EX, then or captured with stallreq_o=0.
REQ-034 lui $7,0xABCD (0x3C07ABCD) -> reg1=0, reg2=0xABCD0000, read enables 0.
REQ-035 sra $6,$8,3 (0x000830C3) -> reg1_read_o=0, reg2_addr_o=8, ex_reg2=3, aluop=7.
REQ-036 stall_i=1 for 3 cycles during valid instruction -> ex_* unchanged; flush_i=1 same cycle as stall_i -> bubble.
REQ-037 rst pulse between clk edges with valid ex_* state -> all ex_* zero immediately; undefined opcode 0xFC000000 -> NOP, wreg 0.
